divisor: RTL and testbench

- Sequential unsigned restoring divider; the inverse operation and companion of the existing multiplicador.
- Uses the same valid_data / Done_Flag / ack handshake, so the same tester-style driver can exercise either unit.
- Produces one quotient bit per clock; results are held until the consumer acknowledges.

---
 rtl/divisor_pkg.sv | 20 ++
 rtl/divisor_paso_resta.sv | 23 ++
 rtl/divisor.sv | 135 +++++++++++++
 tb/tb_divisor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the quotient pattern reported when the divisor is zero.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N = 32;

  // Quotient reported for a zero divisor: all ones at width n (n <= 64).
  function automatic logic [63:0] zero_div_quot(input int n);
    logic [63:0] ones;
    ones = '1;
    return ones >> (64 - n);
  endfunction

endpackage

// File: rtl/divisor_paso_resta.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module paso_resta #(
  parameter int N = 32
) (
  input  logic [N-1:0] r,
  input  logic         a_msb,
  input  logic [N-1:0] b,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  logic [N:0]   r_shift;
  logic [N-1:0] diff;

  // N+1 bits wide so a remainder close to 2^N still compares correctly.
  assign r_shift = {r, a_msb};
  assign q_bit   = (r_shift >= {1'b0, b});
  // When the subtraction is taken the result is below b, so N bits suffice.
  assign diff    = r_shift[N-1:0] - b;
  assign r_next  = q_bit ? diff : r_shift[N-1:0];

endmodule

// File: rtl/divisor.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// valid_data / Done_Flag / ack handshake; results held until acknowledged.
module divisor
  import divisor_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         valid_data,
  input  logic         ack,
  output logic [N-1:0] cociente,
  output logic [N-1:0] residuo,
  output logic         Done_Flag,
  output logic         div_cero
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] QUOT_ZERO_DIV = N'(zero_div_quot(N));

  state_t         state_reg, state_next;
  logic [N-1:0]   a_reg, a_next;
  logic [N-1:0]   b_reg, b_next;
  logic [N-1:0]   r_reg, r_next;
  logic [N-1:0]   coc_reg, coc_next;
  logic [N-1:0]   res_reg, res_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic           done_reg, done_next;
  logic           dz_reg, dz_next;

  logic [N-1:0]   step_r;
  logic           step_q;
  logic           last_step;
  logic           ack_taken;

  paso_resta #(.N(N)) u_paso_resta (
    .r      (r_reg),
    .a_msb  (a_reg[N-1]),
    .b      (b_reg),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  assign last_step = (cnt_reg == CNT_W'(N - 1));
  // ack only counts once the consumer can actually see Done_Flag.
  assign ack_taken = ack && done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_data) state_next = (b != '0) ? CALC : DONE;
      CALC:    if (last_step)  state_next = DONE;
      DONE:    if (ack_taken)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_next    = a_reg;
    b_next    = b_reg;
    r_next    = r_reg;
    cnt_next  = cnt_reg;
    coc_next  = coc_reg;
    res_next  = res_reg;
    dz_next   = dz_reg;
    done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_data) begin
          if (b != '0) begin
            a_next   = a;
            b_next   = b;
            r_next   = '0;
            cnt_next = '0;
          end else begin
            coc_next = QUOT_ZERO_DIV;
            res_next = a;
            dz_next  = 1'b1;
          end
        end
      end
      CALC: begin
        a_next   = {a_reg[N-2:0], step_q};
        r_next   = step_r;
        cnt_next = cnt_reg + CNT_W'(1);
        if (last_step) begin
          coc_next = {a_reg[N-2:0], step_q};
          res_next = step_r;
          dz_next  = 1'b0;
        end
      end
      DONE: begin
        // Flag follows entry into DONE by one edge and drops on the ack edge.
        done_next = !ack_taken;
        if (ack_taken) dz_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      r_reg    <= '0;
      cnt_reg  <= '0;
      coc_reg  <= '0;
      res_reg  <= '0;
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
    end else begin
      a_reg    <= a_next;
      b_reg    <= b_next;
      r_reg    <= r_next;
      cnt_reg  <= cnt_next;
      coc_reg  <= coc_next;
      res_reg  <= res_next;
      done_reg <= done_next;
      dz_reg   <= dz_next;
    end
  end

  assign cociente  = coc_reg;
  assign residuo   = res_reg;
  assign Done_Flag = done_reg;
  assign div_cero  = dz_reg;

endmodule

// File: tb/tb_divisor.sv
// Self-checking bench for divisor: directed corner cases plus random operands
// checked against plain integer division.
module tb_divisor;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic [N-1:0] a, b;
  logic         valid_data;
  logic         ack, ack_drv, loop_mode;
  logic [N-1:0] cociente, residuo;
  logic         Done_Flag, div_cero;

  int checks = 0;
  int errors = 0;

  assign ack = loop_mode ? Done_Flag : ack_drv;

  divisor #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .valid_data (valid_data),
    .ack        (ack),
    .cociente   (cociente),
    .residuo    (residuo),
    .Done_Flag  (Done_Flag),
    .div_cero   (div_cero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation, wait for Done_Flag, compare against integer division.
  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input int exp_lat);
    logic [N-1:0] eq, er;
    int n;
    eq = (bv == 0) ? {N{1'b1}} : av / bv;
    er = (bv == 0) ? av : av % bv;
    @(negedge clk);
    a = av; b = bv; valid_data = 1'b1;
    @(posedge clk); #1;
    valid_data = 1'b0;
    a = $urandom; b = $urandom;
    n = 0;
    while (!Done_Flag && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("cociente", 64'(cociente), 64'(eq));
    check("residuo", 64'(residuo), 64'(er));
    check("div_cero", 64'(div_cero), 64'(bv == 0));
    $display("op a=%0d b=%0d -> q=%0d r=%0d dz=%0b lat=%0d", av, bv, cociente, residuo, div_cero, n);
  endtask

  task automatic do_ack(input logic [N-1:0] eq);
    @(negedge clk);
    ack_drv = 1'b1;
    @(posedge clk); #1;
    ack_drv = 1'b0;
    check("done_after_ack", 64'(Done_Flag), 64'd0);
    check("dz_after_ack", 64'(div_cero), 64'd0);
    check("coc_kept_after_ack", 64'(cociente), 64'(eq));
  endtask

  initial begin
    logic [N-1:0] ra, rb, snap_q, snap_r;
    int changes, n, seen;

    reset = 1'b0; a = '0; b = '0; valid_data = 1'b0; ack_drv = 1'b0; loop_mode = 1'b0;
    #20;
    check("reset_outputs", {cociente, residuo, 30'd0, Done_Flag, div_cero}, 64'd0);
    @(negedge clk); reset = 1'b1;

    run_op(32'd100, 32'd7, N + 1);
    do_ack(32'd14);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, N + 1);
    do_ack(32'd1);
    run_op(32'hFFFFFFFF, 32'd1, N + 1);
    do_ack(32'hFFFFFFFF);

    run_op(32'd5, 32'd0, 1);
    do_ack(32'hFFFFFFFF);

    // Ack hold-off: outputs must stay frozen while ack stays low.
    run_op(32'd12345, 32'd67, N + 1);
    snap_q = cociente; snap_r = residuo; changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cociente !== snap_q || residuo !== snap_r || Done_Flag !== 1'b1) changes++;
    end
    check("holdoff_stable", 64'(changes), 64'd0);
    do_ack(32'd12345 / 32'd67);

    // Random operands, mixing narrow divisors and occasional zero.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(1, 15);
        1: rb = 32'(ra >> $urandom_range(0, 31));
        2: rb = $urandom;
        default: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 100000);
      endcase
      run_op(ra, rb, (rb == 0) ? 1 : N + 1);
      do_ack((rb == 0) ? {N{1'b1}} : ra / rb);
    end

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    a = 32'd999; b = 32'd4; valid_data = 1'b1;
    @(posedge clk); #1;
    valid_data = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("async_reset_outputs", {cociente, residuo, 30'd0, Done_Flag, div_cero}, 64'd0);
    @(negedge clk); reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Done_Flag) seen++;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);

    // Back-to-back with the driver feeding Done_Flag straight back into ack.
    loop_mode = 1'b1;
    @(negedge clk);
    a = 32'd1000; b = 32'd3; valid_data = 1'b1;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd10;
    n = 0;
    while (!Done_Flag && n < 100) begin @(posedge clk); #1; n++; end
    check("b2b_lat1", 64'(n), 64'(N + 1));
    check("b2b_q1", 64'(cociente), 64'd333);
    check("b2b_r1", 64'(residuo), 64'd1);
    $display("b2b first -> q=%0d r=%0d lat=%0d", cociente, residuo, n);
    n = 0;
    while (Done_Flag && n < 10) begin @(posedge clk); #1; n++; end
    check("b2b_ack_one_edge", 64'(n), 64'd1);
    n = 0;
    while (!Done_Flag && n < 100) begin @(posedge clk); #1; n++; end
    valid_data = 1'b0;
    check("b2b_found2", 64'(n < 100), 64'd1);
    check("b2b_q2", 64'(cociente), 64'd0);
    check("b2b_r2", 64'(residuo), 64'd9);
    $display("b2b second -> q=%0d r=%0d", cociente, residuo);
    repeat (3) @(posedge clk); #1;
    check("b2b_idle_after", 64'(Done_Flag), 64'd0);
    loop_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
